// File: rtl/t_mod_counter.sv
// Modulo-MOD up/down counter that extends a single T flip-flop stage: en acts as T.
// It adds parallel load, one-shot stop-at-terminal, and a tc output so instances can be cascaded.
`timescale 1ns/1ps
module t_mod_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qa,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             err
);

    generate
        if (WIDTH < 2 || WIDTH > 16 || MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_param
            $error("t_mod_counter: illegal WIDTH/MOD combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
    localparam int unsigned      MOD_U = MOD;

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic             at_term;
    logic             ld_in_range;

    assign at_term     = up_dn ? (Q == TOP) : (Q == '0);
    assign ld_in_range = (32'(ld_val) < MOD_U);
    assign tc          = en & ~done & at_term;
    assign Qa          = ~Q;

    always_comb begin
        q_nxt    = Q;
        wrap_nxt = 1'b0;
        done_nxt = done;
        err_nxt  = 1'b0;
        if (ld) begin
            done_nxt = 1'b0;
            if (ld_in_range) begin
                q_nxt = ld_val;
            end else begin
                q_nxt   = TOP;
                err_nxt = 1'b1;
            end
        end else if (en && !done) begin
            if (at_term) begin
                // One-shot freezes on the terminal value rather than wrapping.
                if (oneshot) begin
                    done_nxt = 1'b1;
                end else begin
                    q_nxt    = up_dn ? '0 : TOP;
                    wrap_nxt = 1'b1;
                end
            end else begin
                q_nxt = up_dn ? Q + 1'b1 : Q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q    <= '0;
            wrap <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            Q    <= q_nxt;
            wrap <= wrap_nxt;
            done <= done_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_t_mod_counter.sv
// Bench for t_mod_counter: a modulo-arithmetic reference model is compared against the DUT on every falling edge.
// Directed sequences add literal expectations, and a two-stage decimal cascade is also checked.
`timescale 1ns/1ps
module tb_t_mod_counter;
    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst, en, up_dn, ld, oneshot;
    logic [W-1:0] ld_val, q, qa;
    logic         tc, wrap, done, err;

    logic         c_en;
    logic         c_zero = 1'b0;
    logic         c_one  = 1'b1;
    logic [W-1:0] c_ldv  = '0;
    logic [W-1:0] c0_q, c0_qa, c1_q, c1_qa;
    logic         c0_tc, c0_wrap, c0_done, c0_err;
    logic         c1_tc, c1_wrap, c1_done, c1_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    int mq;
    bit mdone, mwrap, merr;

    always #5 clk = ~clk;

    t_mod_counter #(.WIDTH(W), .MOD(M)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .ld(ld), .ld_val(ld_val),
        .oneshot(oneshot), .Q(q), .Qa(qa), .tc(tc), .wrap(wrap), .done(done), .err(err)
    );

    t_mod_counter #(.WIDTH(W), .MOD(M)) c0 (
        .clk(clk), .rst(rst), .en(c_en), .up_dn(c_one), .ld(c_zero), .ld_val(c_ldv),
        .oneshot(c_zero), .Q(c0_q), .Qa(c0_qa), .tc(c0_tc), .wrap(c0_wrap),
        .done(c0_done), .err(c0_err)
    );

    t_mod_counter #(.WIDTH(W), .MOD(M)) c1 (
        .clk(clk), .rst(rst), .en(c0_tc), .up_dn(c_one), .ld(c_zero), .ld_val(c_ldv),
        .oneshot(c_zero), .Q(c1_q), .Qa(c1_qa), .tc(c1_tc), .wrap(c1_wrap),
        .done(c1_done), .err(c1_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modulo arithmetic on an integer count.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq <= 0; mdone <= 1'b0; mwrap <= 1'b0; merr <= 1'b0;
        end else begin
            mwrap <= 1'b0;
            merr  <= 1'b0;
            if (ld) begin
                mdone <= 1'b0;
                if (int'(ld_val) < M) mq <= int'(ld_val);
                else begin mq <= M - 1; merr <= 1'b1; end
            end else if (en && !mdone) begin
                if (oneshot && (up_dn ? mq == M - 1 : mq == 0)) mdone <= 1'b1;
                else if (up_dn) begin mq <= (mq + 1) % M; mwrap <= (mq == M - 1); end
                else begin mq <= (mq + M - 1) % M; mwrap <= (mq == 0); end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_q", int'(q), mq);
            chk("model_qa", int'(qa), (~mq) & ((1 << W) - 1));
            chk("model_tc", int'(tc), int'(en && !mdone && (up_dn ? mq == M - 1 : mq == 0)));
            chk("model_wrap", int'(wrap), int'(mwrap));
            chk("model_done", int'(done), int'(mdone));
            chk("model_err", int'(err), int'(merr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dq[4];
        int dw[4];
        int oq[4];
        int od[4];
        int otc[4];
        int w0 = 0;
        int w1 = 0;

        rst = 1'b1; en = 1'b0; up_dn = 1'b1; ld = 1'b0; ld_val = '0; oneshot = 1'b0; c_en = 1'b0;
        tick();
        chk("reset_q", int'(q), 0);
        chk("reset_qa", int'(qa), 15);
        chk("reset_flags", int'({wrap, done, err}), 0);
        chk_on = 1'b1;

        // Asynchronous reset in the middle of a count.
        rst = 1'b0; en = 1'b1;
        repeat (7) tick();
        chk("pre_reset_q", int'(q), 7);
        rst = 1'b1;
        #1;
        chk("async_reset_q", int'(q), 0);
        chk("async_reset_qa", int'(qa), 15);
        rst = 1'b0;
        tick();
        chk("post_reset_q", int'(q), 1);

        // Up count with wrap.
        ld = 1'b1; ld_val = 4'd0;
        tick();
        ld = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("up_q", int'(q), i);
            chk("up_wrap", int'(wrap), 0);
        end
        chk("up_tc_at_9", int'(tc), 1);
        tick();
        chk("up_wrap_q", int'(q), 0);
        chk("up_wrap_pulse", int'(wrap), 1);
        tick();
        chk("up_after_wrap_q", int'(q), 1);
        chk("up_wrap_cleared", int'(wrap), 0);

        // Down count with wrap.
        dq = '{1, 0, 9, 8};
        dw = '{0, 0, 1, 0};
        ld = 1'b1; ld_val = 4'd2;
        tick();
        ld = 1'b0; up_dn = 1'b0;
        chk("down_load_q", int'(q), 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("down_q", int'(q), dq[i]);
            chk("down_wrap", int'(wrap), dw[i]);
            if (i == 1) chk("down_tc_at_0", int'(tc), 1);
        end

        // One-shot stops at the terminal value.
        oq  = '{8, 9, 9, 9};
        od  = '{0, 0, 1, 1};
        otc = '{0, 1, 0, 0};
        oneshot = 1'b1; up_dn = 1'b1; ld = 1'b1; ld_val = 4'd7;
        tick();
        ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("oneshot_q", int'(q), oq[i]);
            chk("oneshot_done", int'(done), od[i]);
            chk("oneshot_tc", int'(tc), otc[i]);
        end
        up_dn = 1'b0; oneshot = 1'b0;
        tick();
        chk("done_sticky_q", int'(q), 9);
        chk("done_sticky", int'(done), 1);
        ld = 1'b1; ld_val = 4'd3;
        tick();
        chk("done_clear_q", int'(q), 3);
        chk("done_clear", int'(done), 0);

        // Load priority and range checking.
        up_dn = 1'b1; en = 1'b1; ld_val = 4'd5;
        tick();
        chk("ld_priority_q", int'(q), 5);
        chk("ld_priority_err", int'(err), 0);
        ld_val = 4'd12;
        tick();
        chk("ld_oor_q", int'(q), 9);
        chk("ld_oor_err", int'(err), 1);
        ld_val = 4'd9;
        tick();
        chk("ld_max_q", int'(q), 9);
        chk("ld_max_err", int'(err), 0);
        ld_val = 4'd10;
        tick();
        chk("ld_mod_q", int'(q), 9);
        chk("ld_mod_err", int'(err), 1);
        ld = 1'b0; en = 1'b0;
        tick();
        chk("err_pulse_end", int'(err), 0);
        chk("hold_q", int'(q), 9);

        // Direction changes take effect on the very next edge.
        ld = 1'b1; ld_val = 4'd5;
        tick();
        ld = 1'b0; en = 1'b1;
        tick();
        chk("dir_up_q", int'(q), 6);
        up_dn = 1'b0;
        tick();
        chk("dir_down_q", int'(q), 5);
        tick();
        chk("dir_down2_q", int'(q), 4);

        // Two-stage decimal cascade.
        en = 1'b0; c_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            chk("cascade_value", 10 * int'(c1_q) + int'(c0_q), k % 100);
            w0 += int'(c0_wrap);
            w1 += int'(c1_wrap);
        end
        chk("cascade_c0_wrap_last", int'(c0_wrap), 1);
        chk("cascade_c1_wrap_last", int'(c1_wrap), 1);
        chk("cascade_c0_wraps", w0, 10);
        chk("cascade_c1_wraps", w1, 1);
        chk("cascade_qa", int'({c1_qa, c0_qa}), 255);
        chk("cascade_flags", int'({c0_done, c0_err, c1_done, c1_err, c1_tc}), 0);
        c_en = 1'b0;
        tick();

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
